// File: rtl/cs_cmd_mc.sv
// Multi-channel command sequencer: brings up MAC/FIFO/ADC blocks, then runs
// concurrent ADC-acquisition and UDP-transmit loops guarded by watchdogs.
module cs_cmd_mc #(
    parameter int               ADC_NUM  = 4,
    parameter int               CNT_W    = 8,
    parameter int               FIFO_NUM = 3,
    parameter int               RST_CYC  = 4,
    parameter int               WDG_W    = 16,
    parameter logic [WDG_W-1:0] WDG_MAX  = 16'hFFFF
) (
    input  logic                sys_clk,
    input  logic                rst_sys,
    output logic                rst_run,
    input  logic [ADC_NUM-1:0]  adc_en,
    input  logic [CNT_W-1:0]    adc_cnt,
    input  logic [FIFO_NUM-1:0] fifo_full,
    input  logic                fs_adc,
    input  logic                fs_udp_rx,
    output logic                fs_mac2fifoc,
    input  logic                fd_mac2fifoc,
    output logic                fs_fifoc2cs,
    input  logic                fd_fifoc2cs,
    output logic                fd_udp_rx,
    output logic                fs_adc_check,
    input  logic [ADC_NUM-1:0]  fd_adc_check,
    output logic                fs_adc_conf,
    input  logic [ADC_NUM-1:0]  fd_adc_conf,
    output logic                fs_adc_read,
    input  logic [ADC_NUM-1:0]  fd_adc_read,
    output logic                fs_adc_fifo,
    input  logic                fd_adc_fifo,
    output logic                fs_udp_tx,
    output logic                fs_fifod2mac,
    input  logic                fd_fifod2mac,
    output logic                fd_udp_tx,
    output logic [CNT_W-1:0]    frame_num,
    output logic [CNT_W-1:0]    miss_cnt,
    output logic                err,
    output logic [2:0]          err_code
);

    typedef enum logic [2:0] {M_IDLE, M_RESET, M_INIT, M_WORK, M_ERR} main_t;
    typedef enum logic [2:0] {I_IDLE, I_FFCK, I_UTOF, I_FTOC, I_URXD, I_ADCK, I_CONF, I_LAST} init_t;
    typedef enum logic [2:0] {A_IDLE, A_WAIT, A_READ, A_FIFO, A_LAST} adc_t;
    typedef enum logic [1:0] {E_IDLE, E_WAIT, E_CAL, E_SEND} eth_t;

    localparam int               RC_W     = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(RST_CYC - 1);
    localparam logic [WDG_W-1:0] WDG_LAST = WDG_MAX - 1'b1;

    main_t main_q, main_d;
    init_t init_q, init_d, init_n;
    adc_t  adc_q, adc_d, adc_n;
    eth_t  eth_q, eth_d, eth_n;

    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [ADC_NUM-1:0] en_q, en_d;
    logic               fs_adc_q;
    logic [CNT_W-1:0]   frame_q, frame_d, miss_q, miss_d;
    logic [WDG_W-1:0]   wdg_i_q, wdg_i_d, wdg_a_q, wdg_a_d, wdg_e_q, wdg_e_d;
    logic [2:0]         code_q, code_d, err_req;
    logic               rst_run_q, rst_run_d;

    logic adc_edge, chk_done, conf_done, read_done;
    logic init_wait, adc_wait, eth_wait;
    logic exp_i, exp_a, exp_e, ovf;

    assign adc_edge  = fs_adc & ~fs_adc_q;
    assign chk_done  = &(fd_adc_check | ~en_q);
    assign conf_done = &(fd_adc_conf | ~en_q);
    assign read_done = &(fd_adc_read | ~en_q);

    assign init_wait = (init_q != I_IDLE) && (init_q != I_LAST);
    assign adc_wait  = (adc_q == A_READ) || (adc_q == A_FIFO);
    assign eth_wait  = (eth_q == E_SEND);

    // Natural sub-FSM successors, before the main FSM forces them idle.
    always_comb begin
        init_n = init_q;
        case (init_q)
            I_IDLE:  init_n = I_FFCK;
            I_FFCK:  if (~|fifo_full)  init_n = I_UTOF;
            I_UTOF:  if (fd_mac2fifoc) init_n = I_FTOC;
            I_FTOC:  if (fd_fifoc2cs)  init_n = I_URXD;
            I_URXD:  if (~fs_udp_rx)   init_n = I_ADCK;
            I_ADCK:  if (chk_done)     init_n = I_CONF;
            I_CONF:  if (conf_done)    init_n = I_LAST;
            I_LAST:  init_n = I_LAST;
            default: init_n = I_IDLE;
        endcase

        adc_n = adc_q;
        case (adc_q)
            A_IDLE:  adc_n = A_WAIT;
            A_WAIT:  if (adc_edge)    adc_n = A_READ;
            A_READ:  if (read_done)   adc_n = A_FIFO;
            A_FIFO:  if (fd_adc_fifo) adc_n = A_LAST;
            A_LAST:  adc_n = A_WAIT;
            default: adc_n = A_IDLE;
        endcase

        eth_n = eth_q;
        case (eth_q)
            E_IDLE:  eth_n = E_WAIT;
            E_WAIT:  if ((adc_cnt != '0) && (frame_q >= adc_cnt)) eth_n = E_CAL;
            E_CAL:   eth_n = E_SEND;
            E_SEND:  if (fd_fifod2mac) eth_n = E_WAIT;
            default: eth_n = E_IDLE;
        endcase
    end

    assign exp_i = init_wait && (init_n == init_q) && (wdg_i_q == WDG_LAST);
    assign exp_a = adc_wait  && (adc_n == adc_q)   && (wdg_a_q == WDG_LAST);
    assign exp_e = eth_wait  && (eth_n == eth_q)   && (wdg_e_q == WDG_LAST);
    assign ovf   = (adc_q == A_LAST) && (eth_q != E_CAL) && (&frame_q);

    always_comb begin
        err_req = 3'd0;
        if (exp_i)      err_req = 3'd1;
        else if (exp_a) err_req = 3'd2;
        else if (exp_e) err_req = 3'd3;
        else if (ovf)   err_req = 3'd4;

        main_d = main_q;
        case (main_q)
            M_IDLE:  if (fs_udp_rx) main_d = M_RESET;
            M_RESET: if (rst_cnt_q == RC_LAST) main_d = M_INIT;
            M_INIT:  if (err_req != 3'd0) main_d = M_ERR;
                     else if (init_q == I_LAST) main_d = M_WORK;
            M_WORK:  if (err_req != 3'd0) main_d = M_ERR;
                     else if (fs_udp_rx) main_d = M_IDLE;
            M_ERR:   if (fs_udp_rx) main_d = M_RESET;
            default: main_d = M_IDLE;
        endcase

        rst_cnt_d = (main_q == M_RESET) ? rst_cnt_q + 1'b1 : '0;
        rst_run_d = (main_d == M_RESET);

        code_d = code_q;
        if ((main_d == M_ERR) && (main_q != M_ERR))     code_d = err_req;
        if ((main_d == M_RESET) && (main_q != M_RESET)) code_d = 3'd0;

        en_d = ((main_d == M_INIT) && (main_q != M_INIT)) ? adc_en : en_q;

        // Sub-FSMs drop to IDLE on the same edge the main FSM leaves their phase.
        init_d = ((main_d == M_INIT) && (main_q == M_INIT)) ? init_n : I_IDLE;
        adc_d  = ((main_d == M_WORK) && (main_q == M_WORK)) ? adc_n  : A_IDLE;
        eth_d  = ((main_d == M_WORK) && (main_q == M_WORK)) ? eth_n  : E_IDLE;

        wdg_i_d = (init_d != init_q) ? '0 : (init_wait ? wdg_i_q + 1'b1 : wdg_i_q);
        wdg_a_d = (adc_d != adc_q)   ? '0 : (adc_wait  ? wdg_a_q + 1'b1 : wdg_a_q);
        wdg_e_d = (eth_d != eth_q)   ? '0 : (eth_wait  ? wdg_e_q + 1'b1 : wdg_e_q);

        frame_d = frame_q;
        miss_d  = miss_q;
        if (main_d == M_RESET) begin
            frame_d = '0;
            miss_d  = '0;
        end else begin
            if (!ovf)
                frame_d = frame_q + CNT_W'(adc_q == A_LAST)
                                  - ((eth_q == E_CAL) ? adc_cnt : '0);
            if (adc_edge && (main_q == M_WORK) && (adc_q != A_WAIT) && ~&miss_q)
                miss_d = miss_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst_sys) begin
            main_q    <= M_IDLE;
            init_q    <= I_IDLE;
            adc_q     <= A_IDLE;
            eth_q     <= E_IDLE;
            rst_cnt_q <= '0;
            en_q      <= '0;
            fs_adc_q  <= 1'b0;
            frame_q   <= '0;
            miss_q    <= '0;
            wdg_i_q   <= '0;
            wdg_a_q   <= '0;
            wdg_e_q   <= '0;
            code_q    <= 3'd0;
            rst_run_q <= 1'b1;
        end else begin
            main_q    <= main_d;
            init_q    <= init_d;
            adc_q     <= adc_d;
            eth_q     <= eth_d;
            rst_cnt_q <= rst_cnt_d;
            en_q      <= en_d;
            fs_adc_q  <= fs_adc;
            frame_q   <= frame_d;
            miss_q    <= miss_d;
            wdg_i_q   <= wdg_i_d;
            wdg_a_q   <= wdg_a_d;
            wdg_e_q   <= wdg_e_d;
            code_q    <= code_d;
            rst_run_q <= rst_run_d;
        end
    end

    assign rst_run      = rst_run_q;
    assign fs_mac2fifoc = (init_q == I_UTOF);
    assign fs_fifoc2cs  = (init_q == I_FTOC);
    assign fd_udp_rx    = (init_q == I_URXD);
    assign fs_adc_check = (init_q == I_ADCK);
    assign fs_adc_conf  = (init_q == I_CONF);
    assign fs_adc_read  = (adc_q == A_READ);
    assign fs_adc_fifo  = (adc_q == A_FIFO);
    assign fs_udp_tx    = (eth_q == E_SEND);
    assign fs_fifod2mac = (eth_q == E_SEND);
    assign fd_udp_tx    = fd_fifod2mac;
    assign frame_num    = frame_q;
    assign miss_cnt     = miss_q;
    assign err          = (main_q == M_ERR);
    assign err_code     = code_q;

endmodule

// File: tb/tb_cs_cmd_mc.sv
// Directed bench for cs_cmd_mc: bring-up, acquire/send, coincident frame
// update, missed samples, watchdog error and reset during configuration.
module tb_cs_cmd_mc;

    logic       sys_clk = 1'b0;
    logic       rst_sys, fs_adc, fs_udp_rx;
    logic [3:0] adc_en, chan_resp;
    logic [7:0] adc_cnt;
    logic [2:0] fifo_full;
    logic       hold_tx;

    logic       rst_run, fs_mac2fifoc, fd_mac2fifoc, fs_fifoc2cs, fd_fifoc2cs, fd_udp_rx;
    logic       fs_adc_check, fs_adc_conf, fs_adc_read, fs_adc_fifo, fd_adc_fifo;
    logic [3:0] fd_adc_check, fd_adc_conf, fd_adc_read;
    logic       fs_udp_tx, fs_fifod2mac, fd_fifod2mac, fd_udp_tx, err;
    logic [7:0] frame_num, miss_cnt;
    logic [2:0] err_code;

    int errors = 0;
    int checks = 0;
    int cnt_utof = 0, cnt_ftoc = 0, cnt_chk = 0, cnt_conf = 0;
    int cnt_read = 0, cnt_fifo = 0, cnt_tx = 0;
    int tx_rises = 0;
    logic tx_prev = 1'b0;

    always #5 sys_clk = ~sys_clk;

    cs_cmd_mc #(
        .ADC_NUM(4), .CNT_W(8), .FIFO_NUM(3), .RST_CYC(4), .WDG_W(16), .WDG_MAX(16'd16)
    ) dut (
        .sys_clk(sys_clk), .rst_sys(rst_sys), .rst_run(rst_run),
        .adc_en(adc_en), .adc_cnt(adc_cnt), .fifo_full(fifo_full),
        .fs_adc(fs_adc), .fs_udp_rx(fs_udp_rx),
        .fs_mac2fifoc(fs_mac2fifoc), .fd_mac2fifoc(fd_mac2fifoc),
        .fs_fifoc2cs(fs_fifoc2cs), .fd_fifoc2cs(fd_fifoc2cs), .fd_udp_rx(fd_udp_rx),
        .fs_adc_check(fs_adc_check), .fd_adc_check(fd_adc_check),
        .fs_adc_conf(fs_adc_conf), .fd_adc_conf(fd_adc_conf),
        .fs_adc_read(fs_adc_read), .fd_adc_read(fd_adc_read),
        .fs_adc_fifo(fs_adc_fifo), .fd_adc_fifo(fd_adc_fifo),
        .fs_udp_tx(fs_udp_tx), .fs_fifod2mac(fs_fifod2mac), .fd_fifod2mac(fd_fifod2mac),
        .fd_udp_tx(fd_udp_tx), .frame_num(frame_num), .miss_cnt(miss_cnt),
        .err(err), .err_code(err_code)
    );

    // Handshake partners answer two cycles after each start strobe rises.
    always @(negedge sys_clk) begin
        cnt_utof <= fs_mac2fifoc ? cnt_utof + 1 : 0;
        cnt_ftoc <= fs_fifoc2cs  ? cnt_ftoc + 1 : 0;
        cnt_chk  <= fs_adc_check ? cnt_chk  + 1 : 0;
        cnt_conf <= fs_adc_conf  ? cnt_conf + 1 : 0;
        cnt_read <= fs_adc_read  ? cnt_read + 1 : 0;
        cnt_fifo <= fs_adc_fifo  ? cnt_fifo + 1 : 0;
        cnt_tx   <= fs_fifod2mac ? cnt_tx   + 1 : 0;
        tx_prev  <= fs_udp_tx;
        if (fs_udp_tx === 1'b1 && tx_prev === 1'b0) tx_rises <= tx_rises + 1;
    end

    assign fd_mac2fifoc = (cnt_utof >= 2);
    assign fd_fifoc2cs  = (cnt_ftoc >= 2);
    assign fd_adc_check = (cnt_chk  >= 2) ? chan_resp : 4'b0000;
    assign fd_adc_conf  = (cnt_conf >= 2) ? chan_resp : 4'b0000;
    assign fd_adc_read  = (cnt_read >= 2) ? chan_resp : 4'b0000;
    assign fd_adc_fifo  = (cnt_fifo >= 2);
    assign fd_fifod2mac = (cnt_tx >= 2) && !hold_tx;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One fs_adc pulse per frame, with room for READ/FIFO/LAST to finish.
    task automatic applyStimulus(input int frames);
        for (int i = 0; i < frames; i++) begin
            fs_adc = 1'b1;
            tick(1);
            fs_adc = 1'b0;
            tick(7);
        end
    endtask

    function automatic logic [8:0] all_fs();
        return {fs_mac2fifoc, fs_fifoc2cs, fd_udp_rx, fs_adc_check, fs_adc_conf,
                fs_adc_read, fs_adc_fifo, fs_udp_tx, fs_fifod2mac};
    endfunction

    initial begin
        int hi, found, sendc;
        rst_sys   = 1'b1;
        fs_adc    = 1'b0;
        fs_udp_rx = 1'b0;
        adc_en    = 4'b0101;
        chan_resp = 4'b0101;
        adc_cnt   = 8'd3;
        fifo_full = 3'b010;
        hold_tx   = 1'b0;
        tick(2);
        checkOutput("rst_run_in_reset", rst_run, 1);
        checkOutput("err_in_reset", err, 0);
        checkOutput("err_code_in_reset", err_code, 0);
        checkOutput("frame_in_reset", frame_num, 0);
        checkOutput("miss_in_reset", miss_cnt, 0);
        checkOutput("fs_in_reset", all_fs(), 0);
        rst_sys = 1'b0;
        tick(1);
        checkOutput("rst_run_released", rst_run, 0);

        $display("[TB] bring-up");
        fs_udp_rx = 1'b1;
        tick(1);
        fs_udp_rx = 1'b0;
        hi = 0;
        for (int i = 0; i < 20 && rst_run; i++) begin
            hi++;
            tick(1);
        end
        checkOutput("rst_run_cycles", hi, 4);
        tick(4);
        checkOutput("ffck_waits_full", fs_mac2fifoc, 0);
        fifo_full = 3'b000;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick(1);
            if (fs_mac2fifoc) found = 1;
        end
        checkOutput("utof_seen", found, 1);
        found = 0;
        for (int i = 0; i < 15 && found == 0; i++) begin
            tick(1);
            if (fd_udp_rx) found = 1;
        end
        checkOutput("urxd_seen", found, 1);
        found = 0;
        for (int i = 0; i < 15 && found == 0; i++) begin
            tick(1);
            if (fs_adc_conf) found = 1;
        end
        checkOutput("conf_seen", found, 1);
        found = 0;
        for (int i = 0; i < 15 && found == 0; i++) begin
            tick(1);
            if (!fs_adc_conf) found = 1;
        end
        checkOutput("conf_done_masked", found, 1);
        tick(3);
        checkOutput("err_after_bringup", err, 0);

        $display("[TB] acquire and send");
        applyStimulus(2);
        checkOutput("frame_below_thresh", frame_num, 2);
        checkOutput("no_tx_below_thresh", tx_rises, 0);
        applyStimulus(1);
        checkOutput("frame_after_send", frame_num, 0);
        applyStimulus(4);
        checkOutput("frame_after_7", frame_num, 1);
        checkOutput("tx_pulses_7", tx_rises, 2);

        $display("[TB] coincident update");
        adc_cnt = 8'd0;
        applyStimulus(2);
        checkOutput("frame_pre_coincide", frame_num, 3);
        fs_adc = 1'b1;
        tick(1);
        fs_adc = 1'b0;
        tick(3);
        adc_cnt = 8'd3;
        tick(1);
        checkOutput("frame_at_coincide", frame_num, 3);
        tick(1);
        checkOutput("frame_coincide", frame_num, 1);
        tick(4);
        checkOutput("tx_pulses_coincide", tx_rises, 3);

        $display("[TB] missed sample and disabled transmit");
        fs_adc = 1'b1;
        tick(1);
        fs_adc = 1'b0;
        tick(1);
        fs_adc = 1'b1;
        tick(1);
        fs_adc = 1'b0;
        tick(5);
        checkOutput("miss_one", miss_cnt, 1);
        checkOutput("frame_after_miss", frame_num, 2);
        adc_cnt = 8'd0;
        applyStimulus(8);
        checkOutput("frame_disabled_tx", frame_num, 10);
        checkOutput("no_tx_disabled", tx_rises, 3);
        checkOutput("miss_still_one", miss_cnt, 1);

        $display("[TB] eth watchdog");
        hold_tx = 1'b1;
        adc_cnt = 8'd3;
        sendc = 0;
        found = 0;
        for (int i = 0; i < 60 && found == 0; i++) begin
            tick(1);
            if (fs_udp_tx) sendc++;
            if (err) found = 1;
        end
        checkOutput("wdg_err_seen", found, 1);
        checkOutput("wdg_send_cycles", sendc, 16);
        checkOutput("wdg_err_code", err_code, 3);
        checkOutput("wdg_fs_low", all_fs(), 0);
        checkOutput("frame_in_err", frame_num, 7);

        hold_tx   = 1'b0;
        adc_en    = 4'b0000;
        chan_resp = 4'b0000;
        fs_udp_rx = 1'b1;
        tick(1);
        fs_udp_rx = 1'b0;
        checkOutput("err_cleared", err, 0);
        checkOutput("err_code_cleared", err_code, 0);
        checkOutput("rst_run_from_err", rst_run, 1);
        tick(1);
        checkOutput("frame_cleared", frame_num, 0);
        checkOutput("miss_cleared", miss_cnt, 0);

        $display("[TB] empty mask and reset during CONF");
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick(1);
            if (!rst_run) found = 1;
        end
        checkOutput("init_entered", found, 1);
        adc_en = 4'b1111;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (fs_adc_conf) found = 1;
            else tick(1);
        end
        checkOutput("conf_with_empty_mask", found, 1);
        rst_sys = 1'b1;
        tick(1);
        checkOutput("midop_fs_low", all_fs(), 0);
        checkOutput("midop_rst_run", rst_run, 1);
        checkOutput("midop_frame", frame_num, 0);
        checkOutput("midop_miss", miss_cnt, 0);
        checkOutput("midop_err", err, 0);
        rst_sys = 1'b0;
        tick(2);
        checkOutput("midop_idle_after", {rst_run, all_fs()}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cs_cmd_mc.md
Name: cs_cmd_mc

Overview:
- Parametrised multi-channel successor to the system command sequencer. Sequences bring-up of MAC/FIFO/ADC sub-blocks, then runs concurrent ADC-acquisition and UDP-transmit loops.
- New versus the previous generation:
  - ADC_NUM channels with a per-channel enable mask.
  - Programmable reset hold length.
  - Per-loop watchdog timeouts that drive an error state.
  - A saturating frame counter.
  - A missed-sample counter.
- Sits between the UDP/FIFO datapath blocks and the ADC channel controllers.

Parameters:
- ADC_NUM, 4, number of ADC channel controllers (1..16).
- CNT_W, 8, width of the frame, adc_cnt and miss counters.
- FIFO_NUM, 3, number of FIFO full flags monitored.
- RST_CYC, 4, cycles main FSM holds RESET (>=1).
- WDG_W, 16, watchdog counter width.
- WDG_MAX, 16'hFFFF, cycles a single wait state may last before timeout.

Ports:
- sys_clk  in  1  system clock.
- rst_sys  in  1  synchronous active-high reset.
- rst_run  out  1  registered run reset to datapath; high while main in RESET or rst_sys.
- adc_en  in  ADC_NUM  channel enable mask; sampled on INIT entry.
- adc_cnt  in  CNT_W  frames per UDP packet; 0 = transmit disabled.
- fifo_full  in  FIFO_NUM  FIFO full flags.
- fs_adc  in  1  ADC sample strobe (level; rising edge = new sample).
- fs_udp_rx  in  1  command-received level.
- fs_mac2fifoc / fd_mac2fifoc  out/in  1/1  MAC-to-command-FIFO start/done.
- fs_fifoc2cs / fd_fifoc2cs  out/in  1/1  command FIFO-to-sequencer start/done.
- fd_udp_rx  out  1  RX command consumed.
- fs_adc_check / fd_adc_check  out/in  1/ADC_NUM  ADC check start/per-channel done.
- fs_adc_conf / fd_adc_conf  out/in  1/ADC_NUM  ADC config start/per-channel done.
- fs_adc_read / fd_adc_read  out/in  1/ADC_NUM  sample read start/per-channel done.
- fs_adc_fifo / fd_adc_fifo  out/in  1/1  write sample frame to FIFO start/done.
- fs_udp_tx, fs_fifod2mac / fd_fifod2mac  out/in  1/1  packet send start/done.
- fd_udp_tx  out  1  equals fd_fifod2mac.
- frame_num  out  CNT_W  buffered frames not yet sent.
- miss_cnt  out  CNT_W  saturating count of dropped fs_adc edges.
- err  out  1  main FSM in ERR.
- err_code  out  3  0 none, 1 init timeout, 2 adc timeout, 3 eth timeout, 4 frame overflow.

Behaviour:
- Reset: rst_sys high at posedge puts all FSMs in IDLE, and zeroes all counters, en_q, err_code and every fs_*/fd_* output. rst_run reads 1 during reset and 0 on the cycle after release.
- Enable handshake: all fs_* outputs are Moore decodes of state, high for the whole state. Any fd_* acceptance is level-sampled.
- Channel done reduction: "all done" = &(fd_x | ~en_q), where en_q is adc_en registered on INIT entry. If en_q == 0, all-done is immediately true.
- Main FSM:
  - IDLE -> RESET on fs_udp_rx.
  - RESET lasts exactly RST_CYC cycles -> INIT.
  - INIT -> WORK when init reaches LAST.
  - WORK -> IDLE on fs_udp_rx.
  - Any watchdog expiry or overflow while in INIT/WORK -> ERR.
  - ERR -> RESET on fs_udp_rx.
- Sub-FSMs are forced to IDLE while main is not INIT (init) or not WORK (adc, eth).
- Init FSM sequence: IDLE -> FFCK (wait ~|fifo_full) -> UTOF (fd_mac2fifoc) -> FTOC (fd_fifoc2cs) -> URXD (wait ~fs_udp_rx; fd_udp_rx high) -> ADCK (all check done) -> CONF (all conf done) -> LAST.
- ADC FSM sequence: IDLE -> WAIT -> READ (on fs_adc rising edge; edge = fs_adc & ~fs_adc_q) -> FIFO (all read done) -> LAST (fd_adc_fifo) -> WAIT.
- Missed samples: a rising edge detected while adc FSM is not in WAIT increments miss_cnt, saturating at all-ones.
- Eth FSM sequence: IDLE -> WAIT -> CAL (when adc_cnt != 0 and frame_num >= adc_cnt) -> SEND -> WAIT (on fd_fifod2mac).
- frame_num update: next = frame_num + (adc LAST) - (eth CAL ? adc_cnt : 0).
  - Both events in the same cycle apply together.
  - Increment when frame_num is all-ones keeps all-ones and raises overflow (err_code 4).
- Watchdogs: one WDG_W counter per sub-FSM.
  - Cleared on any state change of its own FSM.
  - Increments only in wait states: init FFCK..CONF, adc READ/FIFO, eth SEND.
  - Reaching WDG_MAX triggers ERR with that FSM's code.
  - adc WAIT and eth WAIT never time out.
- Error priority and latching: simultaneous errors latch the lowest code. err_code holds in ERR and clears on RESET entry.
- Mid-operation abort: fs_udp_rx in WORK aborts mid-read/mid-send. All fs_* drop on the next cycle, and counters clear on the following RESET.

Test Plan:
- Bring-up:
  - Stimulus: adc_en=4'b0101; fs_udp_rx pulse; each fd_* returned 2 cycles after its fs_*; channels 1,3 never answer.
  - Expected: rst_run high exactly 4 cycles; init reaches LAST; main WORK; err=0.
- Acquire/send:
  - Stimulus: adc_cnt=3, 7 fs_adc edges.
  - Expected: packet sends after frames 3 and 6; frame_num ends 1; fs_udp_tx pulses twice.
- Coincident update:
  - Stimulus: adc LAST in the same cycle as eth CAL, with frame_num=3, adc_cnt=3.
  - Expected: frame_num becomes 1.
- Missed sample and disabled transmit:
  - Stimulus: fs_adc edge while in READ; adc_cnt=0 with 10 frames.
  - Expected: miss_cnt=1; no send occurs; frame_num=10.
- Watchdog:
  - Stimulus: WDG_MAX=16, withhold fd_fifod2mac.
  - Expected: ERR with err_code=3 after 16 SEND cycles.
  - Follow-up: fs_udp_rx -> RESET, then err_code=0.
- Reset mid-operation:
  - Stimulus: rst_sys asserted during CONF.
  - Expected: next cycle all fs_*=0, all states IDLE, miss_cnt=frame_num=0.
